// File: rtl/mbus_pkg.sv
// Shared mbus constants: response codes, default widths and the stall LFSR seed.
package mbus_pkg;

   localparam int MBUS_DATA_WIDTH = 64;
   localparam int MBUS_ADDR_WIDTH = 32;
   localparam int MBUS_MEM_WORDS_BITS = 12;
   localparam int MBUS_Q_DEPTH_BITS = 2;

   localparam logic [1:0] MBUS_RESP_OKAY   = 2'b00;
   localparam logic [1:0] MBUS_RESP_SLVERR = 2'b10;

   localparam logic [15:0] MBUS_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/mbus_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags; a push while full or a pop
// while empty is ignored, so callers may drive push/pop unconditionally.
module mbus_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0]    store [2**DEPTH_BITS];
   logic [DEPTH_BITS:0] wr_ptr;
   logic [DEPTH_BITS:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                    (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
   assign head    = store[rd_ptr[DEPTH_BITS-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) store[wr_ptr[DEPTH_BITS-1:0]] <= push_data;
   end

endmodule

// File: rtl/mbus_mem_responder.sv
// Memory-side mbus responder: in-order reads from an on-chip array, in-order write commit.
// Optional MBUS_MEM_RAND_STALL_EN adds LFSR-driven stalls on ar/aw/r/b.
module mbus_mem_responder
   import mbus_pkg::*;
#(
   parameter int DATA_WIDTH     = MBUS_DATA_WIDTH,
   parameter int ADDR_WIDTH     = MBUS_ADDR_WIDTH,
   parameter int MEM_WORDS_BITS = MBUS_MEM_WORDS_BITS,
   parameter int Q_DEPTH_BITS   = MBUS_Q_DEPTH_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   mbus_ar_addr,
   input  logic                    mbus_ar_valid,
   output logic                    mbus_ar_ready,
   output logic [DATA_WIDTH-1:0]   mbus_r_data,
   output logic                    mbus_r_valid,
   input  logic                    mbus_r_ready,
   input  logic [ADDR_WIDTH-1:0]   mbus_aw_addr,
   input  logic                    mbus_aw_valid,
   output logic                    mbus_aw_ready,
   input  logic [DATA_WIDTH-1:0]   mbus_w_data,
   input  logic                    mbus_w_valid,
   input  logic [DATA_WIDTH/8-1:0] mbus_w_strb,
   output logic [1:0]              mbus_b_resp,
   output logic                    mbus_b_valid,
   input  logic                    mbus_b_ready,
   output logic                    err_oor,
   output logic                    err_w_ovf
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int HI     = LSB + MEM_WORDS_BITS;

   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
      return (a >> HI) != '0;
   endfunction

   function automatic logic [MEM_WORDS_BITS-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[LSB +: MEM_WORDS_BITS];
   endfunction

   logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_BITS];

   logic                         rq_full, rq_empty;
   logic [DATA_WIDTH-1:0]        rq_head;
   logic                         awq_full, awq_empty;
   logic [ADDR_WIDTH-1:0]        awq_head;
   logic                         wq_full, wq_empty;
   logic [DATA_WIDTH+STRB_W-1:0] wq_head;
   logic                         bq_full, bq_empty;
   logic [1:0]                   bq_head;

   logic                  stall_ar, stall_aw, stall_r, stall_b;
   logic                  ar_fire, aw_fire, r_fire, b_fire;
   logic                  ar_oor, cm_oor, commit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] cm_data;
   logic [STRB_W-1:0]     cm_strb;
   logic [1:0]            cm_resp;

`ifdef MBUS_MEM_RAND_STALL_EN
   logic [15:0] lfsr;
   logic        r_shown, b_shown;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr    <= MBUS_LFSR_SEED;
         r_shown <= 1'b0;
         b_shown <= 1'b0;
      end else begin
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         r_shown <= mbus_r_valid && !mbus_r_ready;
         b_shown <= mbus_b_valid && !mbus_b_ready;
      end
   end

   // A valid already on the bus is never withdrawn; the mask only delays it.
   assign stall_ar = (lfsr[1:0] == 2'b00);
   assign stall_aw = (lfsr[3:2] == 2'b00);
   assign stall_r  = (lfsr[5:4] == 2'b00) && !r_shown;
   assign stall_b  = (lfsr[7:6] == 2'b00) && !b_shown;
`else
   assign stall_ar = 1'b0;
   assign stall_aw = 1'b0;
   assign stall_r  = 1'b0;
   assign stall_b  = 1'b0;
`endif

   // Handshake: a transfer happens on a cycle where valid && ready are both high
   // at the rising edge; readies depend only on registered occupancy (no bypass),
   // and a raised valid holds its payload stable until it is accepted.
   assign mbus_ar_ready = !reset && !rq_full  && !stall_ar;
   assign mbus_aw_ready = !reset && !awq_full && !stall_aw;
   assign mbus_r_valid  = !reset && !rq_empty && !stall_r;
   assign mbus_b_valid  = !reset && !bq_empty && !stall_b;
   assign mbus_r_data   = mbus_r_valid ? rq_head : '0;
   assign mbus_b_resp   = mbus_b_valid ? bq_head : 2'b00;

   assign ar_fire = mbus_ar_valid && mbus_ar_ready;
   assign aw_fire = mbus_aw_valid && mbus_aw_ready;
   assign r_fire  = mbus_r_valid && mbus_r_ready;
   assign b_fire  = mbus_b_valid && mbus_b_ready;

   // Array read is combinational, so a same-cycle commit is not yet visible.
   assign ar_oor  = addr_oor(mbus_ar_addr);
   assign rd_word = ar_oor ? '0 : mem[addr_idx(mbus_ar_addr)];

   assign commit  = !reset && !awq_empty && !wq_empty && !bq_full;
   assign cm_oor  = addr_oor(awq_head);
   assign cm_data = wq_head[DATA_WIDTH+STRB_W-1:STRB_W];
   assign cm_strb = wq_head[STRB_W-1:0];
   assign cm_resp = cm_oor ? MBUS_RESP_SLVERR : MBUS_RESP_OKAY;

   mbus_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_BITS(Q_DEPTH_BITS)) u_rq (
      .clk(clk), .reset(reset), .push(ar_fire), .push_data(rd_word), .pop(r_fire),
      .full(rq_full), .empty(rq_empty), .head(rq_head)
   );

   mbus_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH_BITS(Q_DEPTH_BITS)) u_awq (
      .clk(clk), .reset(reset), .push(aw_fire), .push_data(mbus_aw_addr), .pop(commit),
      .full(awq_full), .empty(awq_empty), .head(awq_head)
   );

   mbus_sync_fifo #(.WIDTH(DATA_WIDTH+STRB_W), .DEPTH_BITS(Q_DEPTH_BITS)) u_wq (
      .clk(clk), .reset(reset), .push(mbus_w_valid), .push_data({mbus_w_data, mbus_w_strb}),
      .pop(commit), .full(wq_full), .empty(wq_empty), .head(wq_head)
   );

   mbus_sync_fifo #(.WIDTH(2), .DEPTH_BITS(Q_DEPTH_BITS)) u_bq (
      .clk(clk), .reset(reset), .push(commit), .push_data(cm_resp), .pop(b_fire),
      .full(bq_full), .empty(bq_empty), .head(bq_head)
   );

   always_ff @(posedge clk) begin
      if (commit && !cm_oor) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (cm_strb[b]) mem[addr_idx(awq_head)][b*8 +: 8] <= cm_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_oor   <= 1'b0;
         err_w_ovf <= 1'b0;
      end else begin
         if ((ar_fire && ar_oor) || (commit && cm_oor)) err_oor <= 1'b1;
         if (mbus_w_valid && wq_full) err_w_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mbus_mem_responder.sv
// Self-checking bench for mbus_mem_responder (default build, stalls disabled):
// queue-level reference model, per-cycle output compare and directed literal checks.
module tb_mbus_mem_responder;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int QD = 4;
   localparam int WORDS = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] ar_addr = '0;
   logic          ar_valid = 1'b0;
   logic          ar_ready;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_ready = 1'b0;
   logic [AW-1:0] aw_addr = '0;
   logic          aw_valid = 1'b0;
   logic          aw_ready;
   logic [DW-1:0] w_data = '0;
   logic          w_valid = 1'b0;
   logic [7:0]    w_strb = 8'hFF;
   logic [1:0]    b_resp;
   logic          b_valid;
   logic          b_ready = 1'b0;
   logic          err_oor;
   logic          err_w_ovf;

   always #5 clk = ~clk;

   mbus_mem_responder dut (
      .clk(clk), .reset(reset),
      .mbus_ar_addr(ar_addr), .mbus_ar_valid(ar_valid), .mbus_ar_ready(ar_ready),
      .mbus_r_data(r_data), .mbus_r_valid(r_valid), .mbus_r_ready(r_ready),
      .mbus_aw_addr(aw_addr), .mbus_aw_valid(aw_valid), .mbus_aw_ready(aw_ready),
      .mbus_w_data(w_data), .mbus_w_valid(w_valid), .mbus_w_strb(w_strb),
      .mbus_b_resp(b_resp), .mbus_b_valid(b_valid), .mbus_b_ready(b_ready),
      .err_oor(err_oor), .err_w_ovf(err_w_ovf)
   );

   int total = 0;
   int bad = 0;

   task automatic chk_word(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image plus the four queues as plain SV queues.
   logic [DW-1:0]   m_mem [WORDS];
   logic [DW-1:0]   exp_q [$];
   logic [1:0]      exp_b [$];
   logic [AW-1:0]   m_aw [$];
   logic [DW+7:0]   m_w [$];
   logic            m_oor = 1'b0;
   logic            m_ovf = 1'b0;

   function automatic logic is_oor(input logic [AW-1:0] a);
      return a >= AW'(WORDS * (DW / 8));
   endfunction

   function automatic int word_of(input logic [AW-1:0] a);
      return int'(a) / (DW / 8);
   endfunction

   always @(posedge clk) begin
      int r_n, b_n, aw_n, w_n;
      logic [AW-1:0] a;
      logic [DW+7:0] w;
      logic [DW-1:0] word;
      if (reset) begin
         exp_q.delete();
         exp_b.delete();
         m_aw.delete();
         m_w.delete();
         m_oor = 1'b0;
         m_ovf = 1'b0;
      end else begin
         r_n = exp_q.size();
         b_n = exp_b.size();
         aw_n = m_aw.size();
         w_n = m_w.size();
         if (r_n > 0 && r_ready) void'(exp_q.pop_front());
         if (b_n > 0 && b_ready) void'(exp_b.pop_front());
         if (ar_valid && r_n < QD) begin
            if (is_oor(ar_addr)) begin
               exp_q.push_back('0);
               m_oor = 1'b1;
            end else begin
               exp_q.push_back(m_mem[word_of(ar_addr)]);
            end
         end
         if (aw_n > 0 && w_n > 0 && b_n < QD) begin
            a = m_aw.pop_front();
            w = m_w.pop_front();
            if (is_oor(a)) begin
               exp_b.push_back(2'b10);
               m_oor = 1'b1;
            end else begin
               word = m_mem[word_of(a)];
               for (int k = 0; k < DW / 8; k++)
                  if (w[k]) word[8*k +: 8] = w[8 + 8*k +: 8];
               m_mem[word_of(a)] = word;
               exp_b.push_back(2'b00);
            end
         end
         if (w_valid) begin
            if (w_n < QD) m_w.push_back({w_data, w_strb});
            else m_ovf = 1'b1;
         end
         if (aw_valid && aw_n < QD) m_aw.push_back(aw_addr);
      end
   end

   // Per-cycle compare, sampled after the negedge input updates settle.
   always @(negedge clk) begin
      #2;
      chk_bit("ar_ready", ar_ready, !reset && exp_q.size() < QD);
      chk_bit("aw_ready", aw_ready, !reset && m_aw.size() < QD);
      chk_bit("r_valid", r_valid, !reset && exp_q.size() != 0);
      chk_bit("b_valid", b_valid, !reset && exp_b.size() != 0);
      chk_word("r_data", r_data, (!reset && exp_q.size() != 0) ? exp_q[0] : 64'h0);
      chk_word("b_resp", 64'(b_resp), (!reset && exp_b.size() != 0) ? 64'(exp_b[0]) : 64'h0);
      chk_bit("err_oor", err_oor, m_oor);
      chk_bit("err_w_ovf", err_w_ovf, m_ovf);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ar();
      bit got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (ar_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk_bit("ar_handshake_timeout", got, 1'b1);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s);
      @(negedge clk);
      aw_valid = 1'b1;
      aw_addr = a;
      w_valid = 1'b1;
      w_data = d;
      w_strb = s;
      @(negedge clk);
      aw_valid = 1'b0;
      w_valid = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      @(negedge clk);
      ar_valid = 1'b1;
      ar_addr = a;
      wait_ar();
      @(negedge clk);
      ar_valid = 1'b0;
      #1;
      chk_bit({name, "_valid"}, r_valid, 1'b1);
      chk_word(name, r_data, exp);
   endtask

   localparam logic [DW-1:0] D0 = 64'h1111_2222_3333_4444;
   localparam logic [DW-1:0] D1 = 64'h5555_6666_7777_8888;
   localparam logic [DW-1:0] D2 = 64'h9999_AAAA_BBBB_CCCC;

   logic [DW-1:0] dvec [3];
   logic [DW-1:0] evec [5];

   initial begin
      dvec[0] = D0; dvec[1] = D1; dvec[2] = D2;
      for (int i = 0; i < 5; i++) evec[i] = 64'hE0E0_0000_0000_0000 + 64'(i + 1);

      // Reset state
      tick(3);
      #1;
      chk_bit("rst_ar_ready", ar_ready, 1'b0);
      chk_bit("rst_aw_ready", aw_ready, 1'b0);
      chk_word("rst_r_data", r_data, 64'h0);
      chk_bit("rst_err_oor", err_oor, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_bit("post_rst_ar_ready", ar_ready, 1'b1);
      chk_bit("post_rst_r_valid", r_valid, 1'b0);
      r_ready = 1'b1;
      b_ready = 1'b1;

      // Single write, response one cycle after commit, then read-back
      @(negedge clk);
      aw_valid = 1'b1; aw_addr = 32'h100;
      w_valid = 1'b1; w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF;
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
      #1;
      chk_bit("b_before_commit", b_valid, 1'b0);
      @(negedge clk);
      #1;
      chk_bit("b_after_commit", b_valid, 1'b1);
      chk_word("b_okay", 64'(b_resp), 64'h0);
      tick(2);
      rd_check("rd_0x100", 32'h100, 64'h0123_4567_89AB_CDEF);

      // Byte strobes
      wr(32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr(32'h8, 64'h0, 8'h0F);
      tick(3);
      rd_check("rd_strobe", 32'h8, 64'hFFFF_FFFF_0000_0000);

      // Write beats ahead of addresses
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         w_valid = 1'b1; w_data = dvec[i]; w_strb = 8'hFF;
      end
      @(negedge clk);
      w_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         aw_valid = 1'b1; aw_addr = 32'(i * 8);
         @(negedge clk);
      end
      aw_valid = 1'b0;
      tick(4);
      for (int i = 0; i < 3; i++) rd_check("rd_early_w", 32'(i * 8), dvec[i]);
      tick(2);

      // Read backpressure: queue holds 4, the fifth waits
      r_ready = 1'b0;
      rd_check("bp_head", 32'h0, D0);
      ar_valid = 1'b1;
      ar_addr = 32'h8;   wait_ar();
      @(negedge clk); ar_addr = 32'h10;  wait_ar();
      @(negedge clk); ar_addr = 32'h100; wait_ar();
      @(negedge clk); ar_addr = 32'h10;
      #1;
      chk_bit("bp_ar_ready_low", ar_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk_word("bp_r_stable", r_data, D0);
      end
      r_ready = 1'b1;
      wait_ar();
      @(negedge clk);
      ar_valid = 1'b0;
      tick(8);

      // Out-of-range read and write
      rd_check("rd_oor", 32'h8000_0000, 64'h0);
      chk_bit("err_oor_set", err_oor, 1'b1);
      tick(2);
      wr(32'h8000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      @(negedge clk);
      #1;
      chk_bit("oor_b_valid", b_valid, 1'b1);
      chk_word("oor_b_slverr", 64'(b_resp), 64'h2);
      tick(2);
      rd_check("rd_after_oor_wr", 32'h0, D0);
      tick(2);

      // w queue overflow
      chk_bit("ovf_clear", err_w_ovf, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         w_valid = 1'b1; w_data = evec[i]; w_strb = 8'hFF;
      end
      @(negedge clk);
      w_valid = 1'b0;
      #1;
      chk_bit("ovf_set", err_w_ovf, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         aw_valid = 1'b1; aw_addr = 32'h18 + 32'(i * 8);
      end
      @(negedge clk);
      aw_valid = 1'b0;
      tick(6);
      for (int i = 0; i < 4; i++) rd_check("rd_ovf_kept", 32'h18 + 32'(i * 8), evec[i]);
      tick(2);

      // Reset mid-burst
      r_ready = 1'b0;
      @(negedge clk);
      ar_valid = 1'b1; ar_addr = 32'h0; wait_ar();
      @(negedge clk); ar_addr = 32'h8; wait_ar();
      @(negedge clk);
      ar_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk_bit("mid_rst_r_valid", r_valid, 1'b0);
      chk_bit("mid_rst_ar_ready", ar_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_bit("after_rst_ar_ready", ar_ready, 1'b1);
      chk_bit("after_rst_r_valid", r_valid, 1'b0);
      chk_bit("after_rst_err_oor", err_oor, 1'b0);
      r_ready = 1'b1;
      tick(5);
      #1;
      chk_bit("no_stale_r", r_valid, 1'b0);
      tick(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
